// File: rtl/sys_cfg_regs_v2.sv
// sys_cfg_regs_v2 - parametrised configuration/status register bank behind the
// AXI BRAM controller port.
//   word k <  REG_NUM : RW control word k (per-byte write strobes)
//   word REG_NUM      : PULSE   (write-only, written lanes pulse for one cycle)
//   word REG_NUM+1    : IRQ_STS (write-1-to-clear, rising-edge capture)
//   word REG_NUM+2    : IRQ_EN  (RW)
//   word REG_NUM+3    : ID      (read-only constant)
// Build option: define SYS_CFG_REGS_IRQ_EN to include the interrupt block.
// Without it IRQ_STS/IRQ_EN decode as unmapped words and irq is tied low.
// Reads are read-first: any hit access loads bram_cfg_rdbk with the addressed
// word's value from before the write.
module sys_cfg_regs_v2 #(
  parameter int                            ADDR_WIDTH  = 32,
  parameter int                            DATA_WIDTH  = 32,
  parameter int                            REG_NUM     = 8,
  parameter logic [REG_NUM*DATA_WIDTH-1:0] REG_RST_VAL = '0,
  parameter logic [ADDR_WIDTH-1:0]         BASE_ADDR   = 32'h0001_0000,
  parameter logic [ADDR_WIDTH-1:0]         BASE_MASK   = 32'hFFFF_0000,
  parameter int                            IRQ_NUM     = 8,
  parameter logic [DATA_WIDTH-1:0]         ID_VAL      = 32'h5253_0002
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            bram_cfg_en,
  input  logic [DATA_WIDTH/8-1:0]         bram_cfg_we,
  input  logic [ADDR_WIDTH-1:0]           bram_cfg_addr,
  input  logic [DATA_WIDTH-1:0]           bram_cfg_data,
  output logic [DATA_WIDTH-1:0]           bram_cfg_rdbk,
  output logic [REG_NUM*DATA_WIDTH-1:0]   reg_out,
  output logic [DATA_WIDTH-1:0]           pulse_out,
  input  logic [IRQ_NUM-1:0]              irq_src,
  output logic                            irq
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = ADDR_WIDTH - 2;

  localparam logic [IW-1:0] K_PULSE = IW'(REG_NUM);
  localparam logic [IW-1:0] K_ID    = IW'(REG_NUM + 3);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] addr_off;
  logic [IW-1:0]         word_idx;
  logic                  acc_hit;
  logic                  wr_hit;
  logic [DATA_WIDTH-1:0] we_bits;
  logic [DATA_WIDTH-1:0] wr_lanes;

  assign addr_off = bram_cfg_addr & ~BASE_MASK;
  // Byte offset bits [1:0] are dropped by the shift.
  assign word_idx = IW'(addr_off >> 2);
  assign acc_hit  = bram_cfg_en && ((bram_cfg_addr & BASE_MASK) == BASE_ADDR);
  assign wr_hit   = acc_hit && (|bram_cfg_we);

  // Expand byte strobes into a per-bit mask so every lane merge is a simple AND/OR.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_we_bits
      assign we_bits[gi*8 +: 8] = {8{bram_cfg_we[gi]}};
    end
  endgenerate

  assign wr_lanes = bram_cfg_data & we_bits;

  // ---------------------------------------------------------------------------
  // Control words
  // ---------------------------------------------------------------------------
  logic [REG_NUM*DATA_WIDTH-1:0] ctrl_flat;

  generate
    for (gi = 0; gi < REG_NUM; gi++) begin : g_ctrl
      logic [DATA_WIDTH-1:0] word_reg;
      logic [DATA_WIDTH-1:0] word_next;

      // Merge strobed lanes into the word when it is the write target.
      always_comb begin
        word_next = word_reg;
        if (wr_hit && (word_idx == IW'(gi))) begin
          word_next = (word_reg & ~we_bits) | wr_lanes;
        end
      end

      // Control word storage, reset to its slice of REG_RST_VAL.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          word_reg <= REG_RST_VAL[gi*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          word_reg <= word_next;
        end
      end

      assign ctrl_flat[gi*DATA_WIDTH +: DATA_WIDTH] = word_reg;
    end
  endgenerate

  assign reg_out = ctrl_flat;

  // ---------------------------------------------------------------------------
  // PULSE word: written lanes are high for exactly the cycle after the write
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] pulse_reg;
  logic [DATA_WIDTH-1:0] pulse_next;

  // Pulse value is the strobed write data, otherwise zero (self-clearing).
  always_comb begin
    pulse_next = '0;
    if (wr_hit && (word_idx == K_PULSE)) begin
      pulse_next = wr_lanes;
    end
  end

  // Pulse register; reset discards any pending pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pulse_reg <= '0;
    end else begin
      pulse_reg <= pulse_next;
    end
  end

  assign pulse_out = pulse_reg;

  // ---------------------------------------------------------------------------
  // Interrupt block
  // ---------------------------------------------------------------------------
`ifdef SYS_CFG_REGS_IRQ_EN
  localparam logic [IW-1:0] K_STS = IW'(REG_NUM + 1);
  localparam logic [IW-1:0] K_EN  = IW'(REG_NUM + 2);

  logic [IRQ_NUM-1:0] src_reg;
  logic [IRQ_NUM-1:0] hist_reg;
  logic [IRQ_NUM-1:0] sts_reg;
  logic [IRQ_NUM-1:0] sts_next;
  logic [IRQ_NUM-1:0] en_reg;
  logic [IRQ_NUM-1:0] en_next;
  logic [IRQ_NUM-1:0] rise;
  logic [IRQ_NUM-1:0] clr_bits;
  logic               irq_reg;
  logic               irq_next;

  // A rise is the registered source high while its one-cycle-older copy is low.
  assign rise = src_reg & ~hist_reg;

  // Status W1C with set priority, enable lane merge, and the irq reduction.
  always_comb begin
    clr_bits = '0;
    en_next  = en_reg;
    if (wr_hit && (word_idx == K_STS)) begin
      clr_bits = wr_lanes[IRQ_NUM-1:0];
    end
    if (wr_hit && (word_idx == K_EN)) begin
      en_next = (en_reg & ~we_bits[IRQ_NUM-1:0]) | wr_lanes[IRQ_NUM-1:0];
    end
    sts_next = (sts_reg & ~clr_bits) | rise;
    irq_next = |(sts_reg & en_reg);
  end

  // Source input register, edge history, status, enable and irq output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      src_reg  <= '0;
      hist_reg <= '0;
      sts_reg  <= '0;
      en_reg   <= '0;
      irq_reg  <= 1'b0;
    end else begin
      src_reg  <= irq_src;
      hist_reg <= src_reg;
      sts_reg  <= sts_next;
      en_reg   <= en_next;
      irq_reg  <= irq_next;
    end
  end

  assign irq = irq_reg;
`else
  // Interrupt block not built: the sources are deliberately left unconsumed.
  logic unused_irq_src;
  assign unused_irq_src = ^irq_src;
  assign irq            = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rdbk_reg;

  // Select the addressed word's current (pre-write) value; unmapped reads 0.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (word_idx == IW'(i)) begin
        rd_word = ctrl_flat[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (word_idx == K_ID) begin
      rd_word = ID_VAL;
    end
`ifdef SYS_CFG_REGS_IRQ_EN
    if (word_idx == K_STS) begin
      rd_word = DATA_WIDTH'(sts_reg);
    end
    if (word_idx == K_EN) begin
      rd_word = DATA_WIDTH'(en_reg);
    end
`endif
  end

  // Read data register: loads on every hit access, holds otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdbk_reg <= '0;
    end else if (acc_hit) begin
      rdbk_reg <= rd_word;
    end
  end

  assign bram_cfg_rdbk = rdbk_reg;

endmodule

// File: tb/tb_sys_cfg_regs_v2.sv
// tb_sys_cfg_regs_v2 - self-checking bench for sys_cfg_regs_v2 (default
// parameters, non-zero control-word reset values). Directed vector table,
// hand-written multi-cycle sequences, then randomized traffic against a
// word-level reference model. Honours SYS_CFG_REGS_IRQ_EN like the design.
module tb_sys_cfg_regs_v2;

  localparam logic [255:0] RST_VAL = {
    32'h8888_0007, 32'h7777_0006, 32'h6666_0005, 32'h5555_0004,
    32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000
  };
  localparam logic [31:0] ID = 32'h5253_0002;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        bram_cfg_en = 1'b0;
  logic [3:0]  bram_cfg_we = 4'h0;
  logic [31:0] bram_cfg_addr = 32'h0;
  logic [31:0] bram_cfg_data = 32'h0;
  logic [31:0] bram_cfg_rdbk;
  logic [255:0] reg_out;
  logic [31:0] pulse_out;
  logic [7:0]  irq_src = 8'h0;
  logic        irq;

  int n_chk = 0;
  int n_fail = 0;

  sys_cfg_regs_v2 #(.REG_RST_VAL(RST_VAL)) dut (
    .clk(clk), .rstn(rstn),
    .bram_cfg_en(bram_cfg_en), .bram_cfg_we(bram_cfg_we),
    .bram_cfg_addr(bram_cfg_addr), .bram_cfg_data(bram_cfg_data),
    .bram_cfg_rdbk(bram_cfg_rdbk), .reg_out(reg_out), .pulse_out(pulse_out),
    .irq_src(irq_src), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic en, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] data);
    bram_cfg_en = en;
    bram_cfg_we = we;
    bram_cfg_addr = addr;
    bram_cfg_data = data;
  endtask

  function automatic logic [31:0] rst_word(input int i);
    return RST_VAL[i*32 +: 32];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // ---------------- reference model (word-level view of the register map) ----
  logic [31:0] m_ctrl [8];
  logic [31:0] m_rdbk, m_pulse;
  logic [7:0]  m_sts, m_en, m_s0, m_s1;
  logic        m_irq;

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_ctrl[i] = rst_word(i);
    m_rdbk = 0; m_pulse = 0; m_sts = 0; m_en = 0; m_s0 = 0; m_s1 = 0; m_irq = 0;
  endtask

  // One clock edge with the given access and irq_src level sampled.
  task automatic m_edge(input logic en, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [7:0] src);
    logic hit;
    int k;
    logic [31:0] rd, tmp;
    logic [7:0] rise, clr;
    logic irq_new;
    hit = en && ((addr & 32'hFFFF_0000) == 32'h0001_0000);
    k = int'((addr & 32'h0000_FFFF) >> 2);
    rd = 0;
    if (k < 8) rd = m_ctrl[k];
    else if (k == 11) rd = ID;
`ifdef SYS_CFG_REGS_IRQ_EN
    else if (k == 9) rd = {24'h0, m_sts};
    else if (k == 10) rd = {24'h0, m_en};
`endif
    rise = m_s0 & ~m_s1;
    irq_new = |(m_sts & m_en);
    clr = 0;
    m_pulse = 0;
    if (hit) begin
      m_rdbk = rd;
      if (we != 0) begin
        if (k < 8) m_ctrl[k] = merge(m_ctrl[k], data, we);
        else if (k == 8) m_pulse = merge(32'h0, data, we);
`ifdef SYS_CFG_REGS_IRQ_EN
        else if (k == 9) begin tmp = merge(32'h0, data, we); clr = tmp[7:0]; end
        else if (k == 10) begin tmp = merge({24'h0, m_en}, data, we); m_en = tmp[7:0]; end
`endif
      end
    end
`ifdef SYS_CFG_REGS_IRQ_EN
    m_sts = (m_sts & ~clr) | rise;
    m_irq = irq_new;
`else
    m_irq = 1'b0;
`endif
    m_s1 = m_s0;
    m_s0 = src;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rdbk;
    logic [31:0] exp_pulse;
  } vec_t;

  vec_t vecs [29];

  initial begin
    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 4'h0, 32'h0001_0000 + 32'(i) * 4, 32'h0, rst_word(i), 32'h0};
    vecs[8]  = '{1'b1, 4'h0, 32'h0001_0020, 32'h0, 32'h0, 32'h0};               // PULSE reads 0
    vecs[9]  = '{1'b1, 4'h0, 32'h0001_0024, 32'h0, 32'h0, 32'h0};               // IRQ_STS
    vecs[10] = '{1'b1, 4'h0, 32'h0001_0028, 32'h0, 32'h0, 32'h0};               // IRQ_EN
    vecs[11] = '{1'b1, 4'h0, 32'h0001_002C, 32'h0, ID, 32'h0};                  // ID
    vecs[12] = '{1'b1, 4'h0, 32'h0001_0030, 32'h0, 32'h0, 32'h0};               // unmapped
    vecs[13] = '{1'b1, 4'h0, 32'h0001_000B, 32'h0, 32'h3333_0002, 32'h0};       // low bits ignored
    vecs[14] = '{1'b1, 4'hF, 32'h0001_0008, 32'hAABB_CCDD, 32'h3333_0002, 32'h0};
    vecs[15] = '{1'b1, 4'h5, 32'h0001_0008, 32'h1122_3344, 32'hAABB_CCDD, 32'h0};
    vecs[16] = '{1'b1, 4'h0, 32'h0001_0008, 32'h0, 32'hAA22_CC44, 32'h0};
    vecs[17] = '{1'b1, 4'hF, 32'h0001_0020, 32'h0000_0081, 32'h0, 32'h0000_0081};
    vecs[18] = '{1'b0, 4'h0, 32'h0001_0020, 32'h0, 32'h0, 32'h0};               // pulse gone
    vecs[19] = '{1'b1, 4'h0, 32'h0001_002C, 32'h0, ID, 32'h0};
    vecs[20] = '{1'b1, 4'hF, 32'h0002_0008, 32'hFFFF_FFFF, ID, 32'h0};          // non-hit
    vecs[21] = '{1'b0, 4'h0, 32'h0001_0008, 32'h0, ID, 32'h0};                  // en low
    vecs[22] = '{1'b1, 4'h0, 32'h0001_0008, 32'h0, 32'hAA22_CC44, 32'h0};
    vecs[23] = '{1'b1, 4'h2, 32'h0001_0020, 32'hFFFF_FFFF, 32'h0, 32'h0000_FF00};
    vecs[24] = '{1'b1, 4'h8, 32'h0001_0020, 32'h1234_5678, 32'h0, 32'h1200_0000};
    vecs[25] = '{1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[26] = '{1'b1, 4'hF, 32'h0001_0030, 32'hDEAD_BEEF, 32'h0, 32'h0};       // unmapped write
    vecs[27] = '{1'b1, 4'h0, 32'h0001_0030, 32'h0, 32'h0, 32'h0};
    vecs[28] = '{1'b1, 4'h0, 32'h0001_0014, 32'hFFFF_FFFF, 32'h6666_0005, 32'h0}; // we=0 is a read
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] r_addr, r_data;
    logic [3:0]  r_we;
    logic        r_en;
    int          sel, k;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdbk", bram_cfg_rdbk, 32'h0);
    check("reset_pulse", pulse_out, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) check($sformatf("reset_reg_out[%0d]", i), reg_out[i*32 +: 32], rst_word(i));

    // Directed table
    for (int i = 0; i < 29; i++) begin
      acc(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].data);
      step();
      $display("vec %0d: en=%b we=%h addr=%h data=%h -> rdbk=%h pulse=%h irq=%b",
               i, vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].data, bram_cfg_rdbk, pulse_out, irq);
      check($sformatf("vec%0d_rdbk", i), bram_cfg_rdbk, vecs[i].exp_rdbk);
      check($sformatf("vec%0d_pulse", i), pulse_out, vecs[i].exp_pulse);
      check($sformatf("vec%0d_irq", i), {31'h0, irq}, 32'h0);
    end
    acc(0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      check($sformatf("table_reg_out[%0d]", i), reg_out[i*32 +: 32], (i == 2) ? 32'hAA22_CC44 : rst_word(i));

`ifdef SYS_CFG_REGS_IRQ_EN
    // Edge capture, W1C, set-wins-over-clear
    acc(1, 4'hF, 32'h0001_0028, 32'h1); step();             // IRQ_EN = 1
    $display("seq: IRQ_EN <= 01, raise irq_src[0]");
    acc(0, 0, 0, 0); irq_src = 8'h01; step();
    check("irq_edge1", {31'h0, irq}, 32'h0);
    step();
    check("irq_edge2", {31'h0, irq}, 32'h0);
    step();
    check("irq_edge3", {31'h0, irq}, 32'h1);
    acc(1, 4'h0, 32'h0001_0024, 32'h0); step();
    check("sts_set", bram_cfg_rdbk, 32'h1);
    $display("seq: W1C IRQ_STS with source held high");
    acc(1, 4'hF, 32'h0001_0024, 32'h1); step();
    check("w1c_read_first", bram_cfg_rdbk, 32'h1);
    acc(1, 4'h0, 32'h0001_0024, 32'h0); step();
    check("sts_cleared", bram_cfg_rdbk, 32'h0);
    check("irq_cleared", {31'h0, irq}, 32'h0);
    acc(0, 0, 0, 0); step(); step();
    check("irq_no_reset_level", {31'h0, irq}, 32'h0);
    acc(1, 4'h0, 32'h0001_0024, 32'h0); step();
    check("sts_no_reset_level", bram_cfg_rdbk, 32'h0);
    acc(0, 0, 0, 0); irq_src = 8'h00; step(); step();
    $display("seq: rising edge coincident with W1C");
    irq_src = 8'h01; step();
    acc(1, 4'hF, 32'h0001_0024, 32'h1); step();
    acc(1, 4'h0, 32'h0001_0024, 32'h0); step();
    check("set_wins", bram_cfg_rdbk, 32'h1);
    check("irq_after_set_wins", {31'h0, irq}, 32'h1);
    acc(1, 4'h0, 32'h0001_0028, 32'h0); step();
    check("en_read", bram_cfg_rdbk, 32'h1);
    acc(1, 4'hF, 32'h0001_0028, 32'hFFFF_FF03); step();
    acc(1, 4'h0, 32'h0001_0028, 32'h0); step();
    check("en_upper_bits_zero", bram_cfg_rdbk, 32'h3);
`else
    // Interrupt block absent: nothing reacts to irq_src or the IRQ words
    $display("seq: IRQ words written, irq_src toggled (no irq block)");
    acc(1, 4'hF, 32'h0001_0028, 32'hFF); step();
    acc(1, 4'hF, 32'h0001_0024, 32'hFF); step();
    acc(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      irq_src = ~irq_src;
      step();
      check($sformatf("irq_off_%0d", i), {31'h0, irq}, 32'h0);
    end
    acc(1, 4'h0, 32'h0001_0024, 32'h0); step();
    check("sts_off_read", bram_cfg_rdbk, 32'h0);
    acc(1, 4'h0, 32'h0001_0028, 32'h0); step();
    check("en_off_read", bram_cfg_rdbk, 32'h0);
`endif

    // Asynchronous reset in the middle of a pulse
    $display("seq: PULSE <= 00000300 then rstn low mid-cycle");
    acc(1, 4'hF, 32'h0001_0020, 32'h0000_0300); step();
    acc(0, 0, 0, 0);
    check("pulse_before_reset", pulse_out, 32'h0000_0300);
`ifdef SYS_CFG_REGS_IRQ_EN
    check("irq_before_reset", {31'h0, irq}, 32'h1);
`endif
    #2 rstn = 1'b0;
    #1;
    check("pulse_async_reset", pulse_out, 32'h0);
    check("irq_async_reset", {31'h0, irq}, 32'h0);
    check("rdbk_async_reset", bram_cfg_rdbk, 32'h0);
    check("word2_async_reset", reg_out[2*32 +: 32], rst_word(2));
    m_reset();
    rstn = 1'b1;

    // Randomized traffic against the reference model
    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 15));
      k = int'($urandom_range(0, 13));
      if (sel == 0) r_addr = 32'h0002_0000 + 32'(k) * 4;
      else if (sel == 1) r_addr = $urandom;
      else r_addr = 32'h0001_0000 + 32'(k) * 4 + $urandom_range(0, 3);
      r_en = ($urandom_range(0, 7) != 0);
      r_we = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      r_data = $urandom;
      irq_src = irq_src ^ 8'($urandom & $urandom & $urandom);
      acc(r_en, r_we, r_addr, r_data);
      step();
      m_edge(r_en, r_we, r_addr, r_data, irq_src);
      if (r_en)
        $display("rnd %0d: we=%h addr=%h data=%h -> rdbk=%h pulse=%h irq=%b",
                 n, r_we, r_addr, r_data, bram_cfg_rdbk, pulse_out, irq);
      check($sformatf("rnd%0d_rdbk", n), bram_cfg_rdbk, m_rdbk);
      check($sformatf("rnd%0d_pulse", n), pulse_out, m_pulse);
      check($sformatf("rnd%0d_irq", n), {31'h0, irq}, {31'h0, m_irq});
      for (int i = 0; i < 8; i++)
        check($sformatf("rnd%0d_reg_out[%0d]", n, i), reg_out[i*32 +: 32], m_ctrl[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
